palette_layer_sequencer: RTL and testbench
==========================================

Name: palette_layer_sequencer

Overview:
- Composites one screen pixel from up to NUM_LAYERS sprite layers (player, spikes, blocks, ground) through a single shared 16-entry palette lookup, time-multiplexed one layer per clock.
- Sits between the per-layer sprite ROM address logic and the VGA colour output register.
- Layer 0 has the highest priority. The first enabled layer whose index is not TRANSP_IDX supplies the colour. If no layer qualifies, the output is BG_RGB.

Parameters:
- NUM_LAYERS, 4, number of layers; legal range 2..8.
- TRANSP_IDX, 4'h0, palette index that is treated as transparent.
- BG_RGB, 12'h36C, {r,g,b} output when every layer is transparent or masked.

Ports:
- clk, input, 1, pixel-domain clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, pixel request valid.
- in_ready, output, 1, request accepted when in_valid && in_ready.
- in_idx, input, 4*NUM_LAYERS, layer k index in bits [4k+3:4k].
- in_mask, input, NUM_LAYERS, layer enable bits.
- pal_index, output, 4, address to the shared palette (combinational lookup).
- pal_red / pal_green / pal_blue, input, 4 each, palette data returned for pal_index in the same cycle.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_red / out_green / out_blue, output, 4 each, composited colour.
- out_collide, output, 1, collision flag (see Optional Feature).
- busy, output, 1, high when state != IDLE.

Behaviour:
- Reset (async, while reset_n=0):
  - state=IDLE, ptr=0.
  - out_valid=0, out_red/green/blue=0, out_collide=0.
  - pal_index=0, busy=0, in_ready=1.
- States are IDLE, SCAN and OUT.
- IDLE:
  - in_ready=1, pal_index=0.
  - On in_valid, latch in_idx/in_mask, set ptr=0, go to SCAN.
- SCAN (one layer per cycle):
  - pal_index = idx[ptr].
  - Layer is a hit when mask[ptr]=1 and idx[ptr]!=TRANSP_IDX.
  - On a hit: register {pal_red,pal_green,pal_blue} into out_* and go to OUT.
  - On a miss with ptr<NUM_LAYERS-1: ptr++.
  - On a miss with ptr=NUM_LAYERS-1: out_*=BG_RGB, go to OUT.
  - A masked layer still consumes one SCAN cycle; no skipping.
- OUT:
  - out_valid=1; out_* and out_collide are held stable.
  - On out_ready: out_valid=0, go to IDLE.
  - in_ready=0 throughout OUT.
- Latency: out_valid is asserted k+1 cycles after the accept edge, where k is the number of layers examined (1..NUM_LAYERS).
- Throughput: one pixel per k+2 cycles minimum. There is no overlap; in_ready is only high in IDLE.
- in_idx/in_mask changing after accept has no effect; they are latched.
- out_ready high while not in OUT is ignored.
- Reset asserted mid-SCAN or mid-OUT aborts immediately with reset values; the pending pixel is dropped.
- ptr width is clog2(NUM_LAYERS) and never exceeds NUM_LAYERS-1.

Optional Feature:
- Macro: PALSEQ_COLLIDE_EN.
- Defined:
  - SCAN always examines all NUM_LAYERS layers; there is no early exit.
  - Colour is still taken from the first hit, registered when it occurs and not overwritten by later hits.
  - out_collide=1 when layer 0 is a hit and any layer 1..NUM_LAYERS-1 is also a hit, else 0.
  - Latency is fixed at NUM_LAYERS+1.
- Undefined: early exit as above; out_collide is tied to 0.

Test Plan:
- Bench palette model: red=idx, green=~idx, blue=4'hA. Defaults throughout; cycles counted from the accept edge. Tests 1–4 assume PALSEQ_COLLIDE_EN undefined; test 5 covers both builds.
- 1. in_idx L0..L3={0,5,7,2}, in_mask=4'hF, out_ready=1 → pal_index 0 then 5; out_valid at cycle 3; out rgb=(5,A,A); in_ready back to 1 at cycle 4.
- 2. in_idx={0,0,0,0}, in_mask=4'hF; then repeat with in_idx={3,4,5,6}, in_mask=4'h0 → both give out_valid at cycle 5, rgb=(3,6,C).
- 3. in_idx={8,...}, in_mask=4'h1, out_ready=0 for 6 cycles then 1 → out_valid at cycle 2 held with rgb=(8,7,A) stable; in_ready=0 and busy=1 throughout; returns to IDLE one cycle after out_ready rises; a second in_valid during the hold is not accepted.
- 4. Request {0,0,9,0} with mask=4'hF; pulse reset_n=0 at cycle 2 (mid-SCAN) → all outputs at reset values immediately; no out_valid for that pixel; next request is accepted normally.
- 5. in_idx={3,0,6,0}, in_mask=4'h5:
  - With PALSEQ_COLLIDE_EN: out_valid at cycle 5, rgb=(3,C,A), out_collide=1.
  - Without: out_valid at cycle 2, same rgb, out_collide=0.
  - Repeat with in_mask=4'h1 → out_collide=0 in both builds.

Source files
------------

// File: rtl/palette_layer_sequencer.sv
// palette_layer_sequencer
// Composites one pixel from NUM_LAYERS sprite layers through a single shared
// palette. One layer is examined per clock, and layer 0 has the highest priority.
// Optional build macro PALSEQ_COLLIDE_EN: every layer is always scanned, and
// out_collide reports a layer-0 hit that overlaps a hit on any other layer.
module palette_layer_sequencer #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter logic [3:0]  TRANSP_IDX = 4'h0,
   parameter logic [11:0] BG_RGB     = 12'h36C
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_LAYERS-1:0] in_idx,
   input  logic [NUM_LAYERS-1:0]   in_mask,
   output logic [3:0]              pal_index,
   input  logic [3:0]              pal_red,
   input  logic [3:0]              pal_green,
   input  logic [3:0]              pal_blue,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_red,
   output logic [3:0]              out_green,
   output logic [3:0]              out_blue,
   output logic                    out_collide,
   output logic                    busy
);

   localparam int unsigned PW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]              r_state;
   logic [PW-1:0]           r_ptr;
   logic [4*NUM_LAYERS-1:0] r_idx;
   logic [NUM_LAYERS-1:0]   r_mask;
   logic [11:0]             r_rgb;
   logic [3:0]              w_cur_idx;
   logic                    w_hit;
   logic                    w_last;
`ifdef PALSEQ_COLLIDE_EN
   logic                    r_got;
   logic                    r_hit0;
   logic                    r_hitn;
   logic                    r_collide;
`endif

   // Current layer's index, its hit qualification, and the last-layer flag
   always_comb begin
      w_cur_idx = r_idx[{r_ptr, 2'b00} +: 4];
      w_hit     = r_mask[r_ptr] && (w_cur_idx != TRANSP_IDX);
      w_last    = (r_ptr == PW'(NUM_LAYERS - 1));
   end

   // Handshake, palette address and output decode
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      out_valid = (r_state == S_OUT);
      pal_index = (r_state == S_SCAN) ? w_cur_idx : 4'h0;
      out_red   = r_rgb[11:8];
      out_green = r_rgb[7:4];
      out_blue  = r_rgb[3:0];
`ifdef PALSEQ_COLLIDE_EN
      out_collide = r_collide;
`else
      out_collide = 1'b0;
`endif
   end

   // Sequencer: latch the request, scan the layers, then hold the result until it is taken
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_mask    <= '0;
         r_rgb     <= '0;
`ifdef PALSEQ_COLLIDE_EN
         r_got     <= 1'b0;
         r_hit0    <= 1'b0;
         r_hitn    <= 1'b0;
         r_collide <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_idx     <= in_idx;
                  r_mask    <= in_mask;
                  r_ptr     <= '0;
                  r_state   <= S_SCAN;
`ifdef PALSEQ_COLLIDE_EN
                  r_got     <= 1'b0;
                  r_hit0    <= 1'b0;
                  r_hitn    <= 1'b0;
                  r_collide <= 1'b0;
`endif
               end
            end
            S_SCAN: begin
`ifdef PALSEQ_COLLIDE_EN
               // The first hit supplies the colour; later hits only feed collision detection
               if (w_hit && !r_got) begin
                  r_rgb <= {pal_red, pal_green, pal_blue};
                  r_got <= 1'b1;
               end
               if (w_hit && (r_ptr == '0)) r_hit0 <= 1'b1;
               if (w_hit && (r_ptr != '0)) r_hitn <= 1'b1;
               if (w_last) begin
                  if (!r_got && !w_hit) r_rgb <= BG_RGB;
                  // The last layer is never layer 0, so a hit here can only count as an "other" hit
                  r_collide <= r_hit0 && (r_hitn || w_hit);
                  r_state   <= S_OUT;
               end else begin
                  r_ptr <= r_ptr + PW'(1);
               end
`else
               if (w_hit) begin
                  r_rgb   <= {pal_red, pal_green, pal_blue};
                  r_state <= S_OUT;
               end else if (w_last) begin
                  r_rgb   <= BG_RGB;
                  r_state <= S_OUT;
               end else begin
                  r_ptr <= r_ptr + PW'(1);
               end
`endif
            end
            S_OUT: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_palette_layer_sequencer.sv
// Directed bench for palette_layer_sequencer (4 layers). The palette model is
// red=idx, green=~idx, blue=A. Cycle c is the interval that ends at the c-th
// clock edge after the accept edge, and it is sampled on the falling edge.
module tb_palette_layer_sequencer;

`ifdef PALSEQ_COLLIDE_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_idx;
   logic [3:0]  in_mask;
   logic [3:0]  pal_index;
   logic [3:0]  pal_red, pal_green, pal_blue;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_red, out_green, out_blue;
   logic        out_collide;
   logic        busy;

   int checks = 0;
   int errors = 0;

   palette_layer_sequencer #(
      .NUM_LAYERS(4),
      .TRANSP_IDX(4'h0),
      .BG_RGB    (12'h36C)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_idx     (in_idx),
      .in_mask    (in_mask),
      .pal_index  (pal_index),
      .pal_red    (pal_red),
      .pal_green  (pal_green),
      .pal_blue   (pal_blue),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_red    (out_red),
      .out_green  (out_green),
      .out_blue   (out_blue),
      .out_collide(out_collide),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      pal_red   = pal_index;
      pal_green = ~pal_index;
      pal_blue  = 4'hA;
   end

   // The cycle in which out_valid is expected, given k layers examined
   function automatic int lat(input int k);
      return COLL ? 5 : k + 1;
   endfunction

   // Issue one request from a falling edge, then scramble the inputs to exercise latching
   task automatic accept(input logic [15:0] idx, input logic [3:0] mask);
      in_idx   = idx;
      in_mask  = mask;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_idx   = 16'hFFFF;
      in_mask  = 4'h0;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_idx    = '0;
      in_mask   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
      checks++; if ({out_red, out_green, out_blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %0h exp 000", {out_red, out_green, out_blue}); end
      checks++; if (out_collide !== 1'b0) begin errors++; $display("FAIL reset_collide got %0h exp 0", out_collide); end
      checks++; if (pal_index !== 4'h0) begin errors++; $display("FAIL reset_pal_index got %0h exp 0", pal_index); end
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_first_hit;
      int v;
      v = lat(2);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hit_ready_pre got %0h exp 1", in_ready); end
      accept(16'h2750, 4'hF);
      for (int c = 1; c <= v + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++; if (pal_index !== 4'h0) begin errors++; $display("FAIL hit_pal_c1 got %0h exp 0", pal_index); end
         end
         if (c == 2) begin
            checks++; if (pal_index !== 4'h5) begin errors++; $display("FAIL hit_pal_c2 got %0h exp 5", pal_index); end
         end
         checks++; if (out_valid !== (c == v)) begin errors++; $display("FAIL hit_valid_c%0d got %0h exp %0h", c, out_valid, (c == v)); end
         if (c == v) begin
            checks++; if ({out_red, out_green, out_blue} !== 12'h5AA) begin errors++; $display("FAIL hit_rgb got %0h exp 5AA", {out_red, out_green, out_blue}); end
         end
         checks++; if (in_ready !== (c > v)) begin errors++; $display("FAIL hit_ready_c%0d got %0h exp %0h", c, in_ready, (c > v)); end
      end
   endtask

   task automatic test_background;
      logic [15:0] idx;
      logic [3:0]  exp_pal;
      int v;
      v = lat(4);
      for (int run = 0; run < 2; run++) begin
         idx = (run == 0) ? 16'h0000 : 16'h6543;
         accept(idx, (run == 0) ? 4'hF : 4'h0);
         for (int c = 1; c <= v + 1; c++) begin
            @(negedge clk);
            if (c <= 4) begin
               exp_pal = idx[4*(c-1) +: 4];
               checks++; if (pal_index !== exp_pal) begin errors++; $display("FAIL bg%0d_pal_c%0d got %0h exp %0h", run, c, pal_index, exp_pal); end
            end
            checks++; if (out_valid !== (c == v)) begin errors++; $display("FAIL bg%0d_valid_c%0d got %0h exp %0h", run, c, out_valid, (c == v)); end
            if (c == v) begin
               checks++; if ({out_red, out_green, out_blue} !== 12'h36C) begin errors++; $display("FAIL bg%0d_rgb got %0h exp 36C", run, {out_red, out_green, out_blue}); end
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int v;
      v = lat(1);
      out_ready = 1'b0;
      accept(16'h3338, 4'h1);
      for (int c = 1; c <= v + 5; c++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got %0h exp 0", c, in_ready); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_c%0d got %0h exp 1", c, busy); end
         checks++; if (out_valid !== (c >= v)) begin errors++; $display("FAIL bp_valid_c%0d got %0h exp %0h", c, out_valid, (c >= v)); end
         if (c >= v) begin
            checks++; if ({out_red, out_green, out_blue} !== 12'h87A) begin errors++; $display("FAIL bp_rgb_c%0d got %0h exp 87A", c, {out_red, out_green, out_blue}); end
         end
         // A second request offered during the hold must be ignored
         if (c == v + 1) begin
            in_idx   = 16'h0001;
            in_mask  = 4'hF;
            in_valid = 1'b1;
         end
         if (c == v + 3) in_valid = 1'b0;
         if (c == v + 5) out_ready = 1'b1;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0h exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h exp 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %0h exp 0", busy); end
   endtask

   task automatic test_reset_abort;
      int v;
      accept(16'h0900, 4'hF);
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %0h exp 1", busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0h exp 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %0h exp 1", in_ready); end
      checks++; if (pal_index !== 4'h0) begin errors++; $display("FAIL abort_pal got %0h exp 0", pal_index); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0h exp 0", out_valid); end
      checks++; if ({out_red, out_green, out_blue} !== 12'h000) begin errors++; $display("FAIL abort_rgb got %0h exp 000", {out_red, out_green, out_blue}); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_dropped_c%0d got %0h exp 0", c, out_valid); end
      end
      v = lat(3);
      accept(16'h0900, 4'hF);
      for (int c = 1; c <= v + 1; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== (c == v)) begin errors++; $display("FAIL abort_next_valid_c%0d got %0h exp %0h", c, out_valid, (c == v)); end
         if (c == v) begin
            checks++; if ({out_red, out_green, out_blue} !== 12'h96A) begin errors++; $display("FAIL abort_next_rgb got %0h exp 96A", {out_red, out_green, out_blue}); end
         end
      end
   endtask

   task automatic test_collide;
      int v;
      for (int run = 0; run < 2; run++) begin
         v = lat(1);
         accept(16'h0603, (run == 0) ? 4'h5 : 4'h1);
         for (int c = 1; c <= v + 1; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== (c == v)) begin errors++; $display("FAIL col%0d_valid_c%0d got %0h exp %0h", run, c, out_valid, (c == v)); end
            if (c == v) begin
               checks++; if ({out_red, out_green, out_blue} !== 12'h3CA) begin errors++; $display("FAIL col%0d_rgb got %0h exp 3CA", run, {out_red, out_green, out_blue}); end
               checks++; if (out_collide !== (COLL && run == 0)) begin errors++; $display("FAIL col%0d_flag got %0h exp %0h", run, out_collide, (COLL && run == 0)); end
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      in_valid = 1'b0;
      test_reset;
      test_first_hit;
      test_background;
      test_backpressure;
      test_reset_abort;
      test_collide;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
